// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
// Loads one 512-bit block as 16 big-endian words, then streams W[0..ROUNDS-1].
// A 16-entry circular buffer holds the most recent 16 schedule words; each
// expanded word overwrites the slot of W[t-16], which is its last consumer.
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64  // legal range 17..64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

  typedef enum logic [0:0] {StLoad, StEmit} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] msg_buf_q [16];

  logic        in_hs;
  logic        out_hs;
  logic        at_last;
  logic [5:0]  next_idx;
  logic [3:0]  next_slot;
  logic        next_is_expanded;
  logic [31:0] w_expand;
  logic [31:0] next_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Handshakes and the next schedule word, computed from the buffer contents.
  always_comb begin
    in_ready         = (state_q == StLoad) & ~rst;
    in_hs            = in_valid & in_ready;
    out_hs           = (state_q == StEmit) & out_valid & out_ready;
    at_last          = (out_idx == LastIdx);
    next_idx         = out_idx + 6'd1;
    next_slot        = next_idx[3:0];
    next_is_expanded = (next_idx[5:4] != 2'b00);
    // 4-bit slot arithmetic wraps mod 16, matching the circular buffer.
    w_expand         = sigma1(msg_buf_q[next_slot - 4'd2])
                     + msg_buf_q[next_slot - 4'd7]
                     + sigma0(msg_buf_q[next_slot - 4'd15])
                     + msg_buf_q[next_slot];
    next_word        = next_is_expanded ? w_expand : msg_buf_q[next_slot];
  end

  // Buffer write: message words while loading, expanded words while emitting.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      msg_buf_q[cnt_q] <= in_word;
    end else if (!rst && out_hs && !at_last && next_is_expanded) begin
      msg_buf_q[next_slot] <= w_expand;
    end
  end

  // Control FSM with registered output word, index, last and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      cnt_q     <= 4'd0;
      out_word  <= 32'd0;
      out_idx   <= 6'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_hs) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              // M[0] was written fifteen handshakes ago.
              state_q   <= StEmit;
              out_word  <= msg_buf_q[0];
              out_idx   <= 6'd0;
              out_last  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        StEmit: begin
          if (out_hs) begin
            if (at_last) begin
              state_q   <= StLoad;
              cnt_q     <= 4'd0;
              out_idx   <= 6'd0;
              out_last  <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              out_idx  <= next_idx;
              out_word <= next_word;
              out_last <= (next_idx == LastIdx);
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule
